module_total_window_acc: RTL and testbench
==========================================

Name: module_total_window_acc

Overview:
- Downstream consumer of the repeat-loop summing stage.
- Takes that stage's 16-bit totals as a valid/ready stream and accumulates WINDOW consecutive totals into one saturating window sum.
- Presents each window sum with a valid/ready handshake to the next stage.
- Provides an early-close (flush) input for partial windows.

Parameters:
- IN_W, 16, width of incoming total (matches upstream out_total).
- WINDOW, 4, samples per window; legal range 1..15.
- OUT_W, 24, width of window sum; legal range IN_W..32; saturates on overflow.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_total  input  IN_W  total from upstream summing stage
- in_valid  input  1  in_total valid
- in_ready  output  1  block can accept a sample
- in_flush  input  1  close current window early
- out_sum  output  OUT_W  window sum, held while out_valid
- out_count  output  4  samples in reported window (1..WINDOW)
- out_sat  output  1  window sum clamped at max
- out_valid  output  1  window result valid
- out_ready  input  1  downstream accepts result

Behaviour:
- Interface: one clock clk; reset rst is synchronous, active-high.
- Reset values: state=IDLE; out_sum=0, out_count=0, out_sat=0, out_valid=0. in_ready=1 in the cycle after reset.
- rst mid-window or mid-HOLD discards partial data. No result is emitted.
- Accept occurs when in_valid && in_ready.
- FSM states:
  - IDLE: acc=0, cnt=0. Accept → acc=in_total, cnt=1, go to ACCUM.
  - ACCUM: each accept adds in_total (zero-extended) to acc and increments cnt.
  - HOLD: results presented on outputs.
- ACCUM → HOLD when post-update cnt==WINDOW.
- WINDOW=1: IDLE → HOLD directly on accept.
- in_ready = (state != HOLD). No input bubbles except during HOLD.
- HOLD: out_valid=1. out_sum, out_count, out_sat are stable until out_ready. On out_valid && out_ready → IDLE; acc and cnt clear next cycle.
- Latency: out_valid rises the cycle after the accept that completes the window.
- Flush rules:
  - in_flush in ACCUM → HOLD next cycle.
  - in_flush plus a same-cycle accept → sample is included, then HOLD.
  - in_flush in IDLE with an accept → HOLD with out_count=1.
  - in_flush in IDLE without an accept → ignored.
  - in_flush in HOLD → ignored.
- Arithmetic:
  - Sum is computed at OUT_W+1 bits.
  - If the result exceeds 2^OUT_W-1, acc clamps to all-ones and sticky sat sets.
  - Sat clears on window release or reset.
  - Defaults (24 bit, WINDOW=4) cannot overflow.
- Upstream in_valid/in_total need not be held when in_ready=0. No combinational path from in_valid to in_ready.

Optional Feature:
- Macro: MODULE_TOTAL_WINDOW_ACC_MAX_EN.
- When defined:
  - Extra output out_max [IN_W-1:0] carries the largest in_total accepted in the window.
  - Valid with out_valid; resets to 0 and clears on window release.
  - Ties keep the existing value.
- When undefined: port and logic are absent, and behaviour is otherwise identical.

Decomposition:
- Package module_total_window_acc_pkg holds:
  - typedef enum logic [1:0] {IDLE, ACCUM, HOLD} win_state_t
  - localparam CNT_W=4
  - function sat_add(acc, val) returning sum and overflow flag
- One natural sub-module: module_total_sat_adder, a parameterised OUT_W combinational saturating adder. Everything else is flat.

Test Plan:
- Reset then stream 10,20,30,40 back-to-back → one cycle after the 40 accept: out_valid=1, out_sum=100, out_count=4, out_sat=0; in_ready=0 until out_ready.
- Complete a window with out_ready held low for 5 cycles → out_sum stable and in_ready=0 for all 5. After out_ready=1 for one cycle, the next sample 7 is accepted.
- Accept 5,6, then flush alone → out_sum=11, out_count=2. Flush in IDLE alone → no out_valid.
- OUT_W=17, feed 0xFFFF×4 → out_sum=0x1FFFF, out_sat=1. The next window 1,1,1,1 → out_sum=4, out_sat=0.
- Assert rst mid-window after 2 samples → out_valid stays 0. A subsequent 1,2,3,4 window yields out_sum=10, out_count=4.
- With MODULE_TOTAL_WINDOW_ACC_MAX_EN, window 3,9,9,2 → out_max=9, out_sum=23.

Source files
------------

// File: rtl/module_total_window_acc_pkg.sv
// module_total_window_acc_pkg: shared state type, counter width and saturating-add helper
package module_total_window_acc_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} win_state_t;
  localparam int CNT_W = 4;
  typedef struct packed {
    logic [31:0] sum;
    logic ovf;
  } sat_res_t;
  function automatic sat_res_t sat_add(input logic [31:0] acc, input logic [31:0] val, input int unsigned w);
    logic [32:0] s;
    logic [32:0] m;
    sat_res_t r;
    s = {1'b0, acc} + {1'b0, val};
    m = (33'd1 << w) - 33'd1;
    r.ovf = s > m;
    r.sum = r.ovf ? m[31:0] : s[31:0];
    return r;
  endfunction
endpackage

// File: rtl/module_total_sat_adder.sv
// module_total_sat_adder: OUT_W-bit combinational adder clamping to all-ones on overflow
module module_total_sat_adder
  import module_total_window_acc_pkg::*;
#(
  parameter int OUT_W = 24
) (
  input  logic [OUT_W-1:0] a,
  input  logic [OUT_W-1:0] b,
  output logic [OUT_W-1:0] sum,
  output logic             ovf
);
  // Low OUT_W+1 bits of the packed result are {sum[OUT_W-1:0], ovf}
  assign {sum, ovf} = (OUT_W + 1)'(sat_add(32'(a), 32'(b), OUT_W));
endmodule

// File: rtl/module_total_window_acc.sv
// module_total_window_acc: sums WINDOW upstream totals into a saturating window result.
// Optional MODULE_TOTAL_WINDOW_ACC_MAX_EN adds out_max, the largest sample in the window.
module module_total_window_acc
  import module_total_window_acc_pkg::*;
#(
  parameter int IN_W   = 16,
  parameter int WINDOW = 4,
  parameter int OUT_W  = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IN_W-1:0]    in_total,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_flush,
  output logic [OUT_W-1:0]   out_sum,
  output logic [CNT_W-1:0]   out_count,
  output logic               out_sat,
  output logic               out_valid,
  input  logic               out_ready
`ifdef MODULE_TOTAL_WINDOW_ACC_MAX_EN
  ,
  output logic [IN_W-1:0]    out_max
`endif
);
  win_state_t       state;
  logic [OUT_W-1:0] acc;
  logic [OUT_W-1:0] sum;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] nxt_cnt;
  logic             sat;
  logic             ovf;
  logic             accept;
  logic             done;
  assign in_ready  = state != HOLD;
  assign accept    = in_valid && in_ready;
  assign nxt_cnt   = cnt + 1'b1;
  assign done      = (nxt_cnt == CNT_W'(WINDOW)) || in_flush;
  assign out_sum   = acc;
  assign out_count = cnt;
  assign out_sat   = sat;
  assign out_valid = state == HOLD;
  // acc is zero in IDLE, so the first sample needs no special path
  module_total_sat_adder #(.OUT_W(OUT_W)) u_add (
    .a  (acc),
    .b  (OUT_W'(in_total)),
    .sum(sum),
    .ovf(ovf)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      sat   <= 1'b0;
    end else if (state == HOLD) begin
      if (out_ready) begin
        state <= IDLE;
        acc   <= '0;
        cnt   <= '0;
        sat   <= 1'b0;
      end
    end else if (accept) begin
      acc   <= sum;
      cnt   <= nxt_cnt;
      sat   <= sat | ovf;
      state <= done ? HOLD : ACCUM;
    end else if (in_flush && state == ACCUM) begin
      state <= HOLD;
    end
  end
`ifdef MODULE_TOTAL_WINDOW_ACC_MAX_EN
  always_ff @(posedge clk) begin
    if (rst || (state == HOLD && out_ready)) out_max <= '0;
    else if (accept && in_total > out_max) out_max <= in_total;
  end
`endif
endmodule

// File: tb/tb_module_total_window_acc.sv
// tb_module_total_window_acc: directed checks of the window accumulator (default and 17-bit sum builds)
module tb_module_total_window_acc;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_total;
  logic        in_valid, in_flush, out_ready;
  logic        in_ready, out_sat, out_valid;
  logic [23:0] out_sum;
  logic [3:0]  out_count;
  logic [15:0] b_total;
  logic        b_valid, b_flush, b_oready;
  logic        b_iready, b_sat, b_ovalid;
  logic [16:0] b_sum;
  logic [3:0]  b_count;
`ifdef MODULE_TOTAL_WINDOW_ACC_MAX_EN
  logic [15:0] out_max, b_max;
`endif
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  module_total_window_acc dut (
    .clk(clk), .rst(rst), .in_total(in_total), .in_valid(in_valid), .in_ready(in_ready),
    .in_flush(in_flush), .out_sum(out_sum), .out_count(out_count), .out_sat(out_sat),
    .out_valid(out_valid), .out_ready(out_ready)
`ifdef MODULE_TOTAL_WINDOW_ACC_MAX_EN
    , .out_max(out_max)
`endif
  );

  module_total_window_acc #(.OUT_W(17)) dut17 (
    .clk(clk), .rst(rst), .in_total(b_total), .in_valid(b_valid), .in_ready(b_iready),
    .in_flush(b_flush), .out_sum(b_sum), .out_count(b_count), .out_sat(b_sat),
    .out_valid(b_ovalid), .out_ready(b_oready)
`ifdef MODULE_TOTAL_WINDOW_ACC_MAX_EN
    , .out_max(b_max)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] v);
    in_valid = 1'b1;
    in_total = v;
    step();
    in_valid = 1'b0;
  endtask

  task automatic push_b(input logic [15:0] v);
    b_valid = 1'b1;
    b_total = v;
    step();
    b_valid = 1'b0;
  endtask

  task automatic release_a();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_total = '0; in_valid = 0; in_flush = 0; out_ready = 0;
    b_total = '0; b_valid = 0; b_flush = 0; b_oready = 0;
    step(); step();
    rst = 1'b0;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_sum", 32'(out_sum), 0);
    chk("rst_count", 32'(out_count), 0);
    chk("rst_sat", 32'(out_sat), 0);
    chk("rst_ready", 32'(in_ready), 1);
    // back-to-back full window
    push(10); push(20); push(30); push(40);
    chk("w1_valid", 32'(out_valid), 1);
    chk("w1_sum", 32'(out_sum), 100);
    chk("w1_count", 32'(out_count), 4);
    chk("w1_sat", 32'(out_sat), 0);
    chk("w1_ready", 32'(in_ready), 0);
    // stall downstream for 5 cycles
    in_valid = 1'b1; in_total = 16'd999;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_sum", 32'(out_sum), 100);
      chk("stall_ready", 32'(in_ready), 0);
    end
    in_valid = 1'b0;
    release_a();
    chk("rel_valid", 32'(out_valid), 0);
    chk("rel_ready", 32'(in_ready), 1);
    push(7);
    chk("after_rel_count", 32'(out_count), 1);
    chk("after_rel_sum", 32'(out_sum), 7);
    in_flush = 1'b1; step(); in_flush = 1'b0;
    chk("flush1_valid", 32'(out_valid), 1);
    chk("flush1_count", 32'(out_count), 1);
    release_a();
    // partial window closed by flush alone
    push(5); push(6);
    chk("partial_novalid", 32'(out_valid), 0);
    in_flush = 1'b1; step(); in_flush = 1'b0;
    chk("flush2_valid", 32'(out_valid), 1);
    chk("flush2_sum", 32'(out_sum), 11);
    chk("flush2_count", 32'(out_count), 2);
    release_a();
    // flush in IDLE with nothing accepted is ignored
    in_flush = 1'b1; step(); in_flush = 1'b0; step();
    chk("idle_flush_valid", 32'(out_valid), 0);
    chk("idle_flush_count", 32'(out_count), 0);
    // flush with accept in IDLE
    in_flush = 1'b1; push(9); in_flush = 1'b0;
    chk("idle_acc_flush_valid", 32'(out_valid), 1);
    chk("idle_acc_flush_sum", 32'(out_sum), 9);
    chk("idle_acc_flush_count", 32'(out_count), 1);
    release_a();
    // flush with same-cycle accept in ACCUM
    push(2);
    in_flush = 1'b1; push(3); in_flush = 1'b0;
    chk("acc_flush_sum", 32'(out_sum), 5);
    chk("acc_flush_count", 32'(out_count), 2);
    release_a();
    // flush during HOLD is ignored
    push(1); push(1); push(1); push(1);
    in_flush = 1'b1; step(); in_flush = 1'b0;
    chk("hold_flush_valid", 32'(out_valid), 1);
    chk("hold_flush_sum", 32'(out_sum), 4);
    release_a();
    // reset mid-window discards data
    push(8); push(8);
    rst = 1'b1; step(); rst = 1'b0;
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_count", 32'(out_count), 0);
    step();
    chk("midrst_valid2", 32'(out_valid), 0);
    push(1); push(2); push(3); push(4);
    chk("post_rst_sum", 32'(out_sum), 10);
    chk("post_rst_count", 32'(out_count), 4);
    release_a();
`ifdef MODULE_TOTAL_WINDOW_ACC_MAX_EN
    push(3); push(9); push(9); push(2);
    chk("max_val", 32'(out_max), 9);
    chk("max_sum", 32'(out_sum), 23);
    release_a();
    chk("max_clear", 32'(out_max), 0);
`endif
    // 17-bit build saturates
    push_b(16'hFFFF); push_b(16'hFFFF); push_b(16'hFFFF); push_b(16'hFFFF);
    chk("sat_valid", 32'(b_ovalid), 1);
    chk("sat_sum", 32'(b_sum), 32'h1FFFF);
    chk("sat_flag", 32'(b_sat), 1);
    chk("sat_count", 32'(b_count), 4);
    b_oready = 1'b1; step(); b_oready = 1'b0;
    chk("sat_cleared", 32'(b_sat), 0);
    push_b(1); push_b(1); push_b(1); push_b(1);
    chk("nosat_sum", 32'(b_sum), 4);
    chk("nosat_flag", 32'(b_sat), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
